// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
//
// Pipelined barrel shifter for the ALU datapath. Supports logical left/right,
// arithmetic right, rotate left and rotate right on a power-of-two WIDTH
// operand. Each of the L = log2(WIDTH) register stages applies one shift
// weight. Stage S0 applies the largest weight (WIDTH/2) and S(L-1) applies
// weight 1. A sideband tag travels with every request and is returned
// unchanged.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   flush        synchronous kill of every in-flight request (and same-cycle input)
//   in_valid     request valid
//   in_ready     request accepted when in_valid && in_ready
//   in_data      operand
//   in_shamt     shift amount 0..WIDTH-1
//   in_mode      000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
//   in_tag       opaque sideband
//   out_valid    result valid (driven straight from the last stage)
//   out_ready    consumer accepts when out_valid && out_ready
//   out_data     shifted result
//   out_tag      tag of this result
//   out_illegal  result came from a reserved mode (data passed through)
//   busy         any stage holds a valid request
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until the transfer.
// in_ready depends combinationally on out_ready through the advance chain, so
// a full pipeline can accept and emit in the same cycle.
// -----------------------------------------------------------------------------
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int L    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [L-1:0]     in_shamt,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // -------------------------------------------------------------------------
    // Stage state
    // -------------------------------------------------------------------------
    logic [L-1:0]     valid_q,   valid_d;
    logic [L-1:0]     illegal_q, illegal_d;
    logic [WIDTH-1:0] data_q  [L];
    logic [WIDTH-1:0] data_d  [L];
    logic [L-1:0]     shamt_q [L];
    logic [L-1:0]     shamt_d [L];
    logic [2:0]       mode_q  [L];
    logic [2:0]       mode_d  [L];
    logic [TAG_W-1:0] tag_q   [L];
    logic [TAG_W-1:0] tag_d   [L];

    // Per-stage input view: S0 reads the request ports, Sk reads S(k-1).
    logic [WIDTH-1:0] src_data    [L];
    logic [L-1:0]     src_shamt   [L];
    logic [2:0]       src_mode    [L];
    logic [TAG_W-1:0] src_tag     [L];
    logic [L-1:0]     src_illegal;

    // adv[k]  : stage k hands its contents downstream (or out) this edge.
    // load[k] : stage k is written with new contents this edge.
    logic [L-1:0] adv;
    logic [L-1:0] load;

    // -------------------------------------------------------------------------
    // One shift level. sh is a constant power of two per stage and never
    // exceeds WIDTH/2, so the rotate complement (WIDTH - sh) stays in range.
    // SRA fills with the current MSB; earlier levels preserve the sign bit,
    // so this always equals the operand sign.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input logic             en,
        input int               sh
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (en) begin
            case (mode)
                MODE_SLL: r = d << sh;
                MODE_SRL: r = d >> sh;
                MODE_SRA: r = $signed(d) >>> sh;
                MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
                MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
                default:  r = d;
            endcase
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Advance chain, evaluated from the output back toward the input so that
    // a drain at the tail can ripple into in_ready in the same cycle. A stage
    // advances when it is valid and the next stage is empty or itself moving,
    // which lets bubbles collapse while the tail is stalled.
    // -------------------------------------------------------------------------
    always_comb begin
        adv        = '0;
        adv[L-1]   = valid_q[L-1] && out_ready;
        for (int k = L - 2; k >= 0; k--) begin
            adv[k] = valid_q[k] && (!valid_q[k+1] || adv[k+1]);
        end
        in_ready = !flush && (!valid_q[0] || adv[0]);

        load    = '0;
        load[0] = in_valid && in_ready;
        for (int k = 1; k < L; k++) begin
            load[k] = adv[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // Stage sources
    // -------------------------------------------------------------------------
    always_comb begin
        src_data[0]    = in_data;
        src_shamt[0]   = in_shamt;
        src_mode[0]    = in_mode;
        src_tag[0]     = in_tag;
        src_illegal    = '0;
        // Reserved modes are flagged once at entry and carried down the pipe.
        src_illegal[0] = (in_mode > MODE_ROR);
        for (int k = 1; k < L; k++) begin
            src_data[k]    = data_q[k-1];
            src_shamt[k]   = shamt_q[k-1];
            src_mode[k]    = mode_q[k-1];
            src_tag[k]     = tag_q[k-1];
            src_illegal[k] = illegal_q[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Payload registers only change on a load; a stage
    // that drains without being refilled just drops its valid bit.
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        illegal_d = illegal_q;
        for (int k = 0; k < L; k++) begin
            data_d[k]  = data_q[k];
            shamt_d[k] = shamt_q[k];
            mode_d[k]  = mode_q[k];
            tag_d[k]   = tag_q[k];
        end

        for (int k = 0; k < L; k++) begin
            if (load[k]) begin
                valid_d[k]   = 1'b1;
                data_d[k]    = stage_shift(src_data[k], src_mode[k],
                                           src_shamt[k][L-1-k], 1 << (L - 1 - k));
                // Keep only the shift bits still to be applied downstream.
                shamt_d[k]   = src_shamt[k];
                shamt_d[k][L-1-k] = 1'b0;
                mode_d[k]    = src_mode[k];
                tag_d[k]     = src_tag[k];
                illegal_d[k] = src_illegal[k];
            end else if (adv[k]) begin
                valid_d[k]   = 1'b0;
            end
        end

        // Flush only kills valid bits; payload contents are don't-care.
        if (flush) begin
            valid_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= '0;
            illegal_q <= '0;
            for (int k = 0; k < L; k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                mode_q[k]  <= '0;
                tag_q[k]   <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            for (int k = 0; k < L; k++) begin
                data_q[k]  <= data_d[k];
                shamt_q[k] <= shamt_d[k];
                mode_q[k]  <= mode_d[k];
                tag_q[k]   <= tag_d[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from the last stage.
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid   = valid_q[L-1];
        out_data    = data_q[L-1];
        out_tag     = tag_q[L-1];
        out_illegal = illegal_q[L-1];
        busy        = |valid_q;
    end

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
//
// Bench for shift_pipe: a WIDTH=32 instance carries directed, backpressure,
// reset, flush and random traffic; a WIDTH=8 instance carries a short
// directed rotate with its 3-stage latency.
// -----------------------------------------------------------------------------
module tb_shift_pipe;

    localparam int W   = 32;
    localparam int TW  = 5;
    localparam int LAT = 5;
    localparam int EW  = 1 + TW + W;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // WIDTH=32 instance signals
    logic          flush, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
    logic [W-1:0]  in_data, out_data;
    logic [4:0]    in_shamt;
    logic [2:0]    in_mode;
    logic [TW-1:0] in_tag, out_tag;

    // WIDTH=8 instance signals
    logic          flush8, in8_valid, in8_ready, out8_valid, out8_ready, out8_illegal, busy8;
    logic [7:0]    in8_data, out8_data;
    logic [2:0]    in8_shamt;
    logic [2:0]    in8_mode;
    logic [TW-1:0] in8_tag, out8_tag;

    shift_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_shamt    (in_shamt),
        .in_mode     (in_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    shift_pipe #(.WIDTH(8), .TAG_W(TW)) u_dut8 (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush8),
        .in_valid    (in8_valid),
        .in_ready    (in8_ready),
        .in_data     (in8_data),
        .in_shamt    (in8_shamt),
        .in_mode     (in8_mode),
        .in_tag      (in8_tag),
        .out_valid   (out8_valid),
        .out_ready   (out8_ready),
        .out_data    (out8_data),
        .out_tag     (out8_tag),
        .out_illegal (out8_illegal),
        .busy        (busy8)
    );

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: whole shift computed in one step on a 64-bit value.
    function automatic logic [EW-1:0] model(input logic [W-1:0] d, input int s,
                                            input logic [2:0] m, input logic [TW-1:0] t);
        logic [63:0] dd, mask, r;
        logic        ill;
        dd   = {32'b0, d};
        mask = 64'h0000_0000_FFFF_FFFF;
        ill  = 1'b0;
        case (m)
            3'd0: r = (dd << s) & mask;
            3'd1: r = dd >> s;
            3'd2: r = d[W-1] ? ((dd >> s) | (mask & ~(mask >> s))) : (dd >> s);
            3'd3: r = ((dd << s) | (dd >> (W - s))) & mask;
            3'd4: r = ((dd >> s) | (dd << (W - s))) & mask;
            default: begin
                r   = dd;
                ill = 1'b1;
            end
        endcase
        return {ill, t, r[W-1:0]};
    endfunction

    // -------------------------------------------------------------------------
    // Scoreboard: sampled mid-cycle, between drive and the next active edge.
    // -------------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    logic          held = 1'b0;
    logic [EW-1:0] held_val;
    int            n_out = 0;

    always @(negedge clock) begin
        logic [EW-1:0] got, e;
        got = {out_illegal, out_tag, out_data};
        if (!reset_n) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (out_valid && held) check("stable_while_stalled", 64'(got), 64'(held_val));
            held = 1'b0;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(got), 64'(e));
                end
            end else if (out_valid) begin
                held     = 1'b1;
                held_val = got;
            end
            if (flush) begin
                exp_q.delete();
                held = 1'b0;
            end else if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, int'(in_shamt), in_mode, in_tag));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks (called at posedge + 1)
    // -------------------------------------------------------------------------
    task automatic send(input logic [W-1:0] d, input logic [4:0] s, input logic [2:0] m,
                        input logic [TW-1:0] t, output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        in_tag   = t;
        @(negedge clock);
        while (!in_ready && stalls < 500) begin
            stalls++;
            @(negedge clock);
        end
        if (stalls >= 500) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Single request with out_ready high: checks latency and result value.
    task automatic single(input string name, input logic [W-1:0] d, input logic [4:0] s,
                          input logic [2:0] m, input logic [W-1:0] exp_d, input logic exp_ill);
        int st, lat;
        send(d, s, m, 5'd9, st);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_data"}, 64'(out_data), 64'(exp_d));
        check({name, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            n++;
            @(negedge clock);
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic count_outputs(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (out_valid) n++;
        end
        @(posedge clock);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int st, n, lat, first_stall, out_before;
        bit rand_done;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        flush8    = 1'b0;
        in8_valid = 1'b0;
        in8_data  = '0;
        in8_shamt = '0;
        in8_mode  = '0;
        in8_tag   = '0;
        out8_ready = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_w8_out_valid", 64'(out8_valid), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed single requests
        single("sll31", 32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000, 1'b0);
        single("srl31", 32'h8000_0000, 5'd31, 3'b001, 32'h0000_0001, 1'b0);
        single("sra4",  32'h8000_0010, 5'd4,  3'b010, 32'hF800_0001, 1'b0);
        single("ror4",  32'h0000_00F1, 5'd4,  3'b100, 32'h1000_000F, 1'b0);
        single("rol1",  32'h8000_0001, 5'd1,  3'b011, 32'h0000_0003, 1'b0);
        single("mode7", 32'h1234_5678, 5'd9,  3'b111, 32'h1234_5678, 1'b1);
        single("sra0",  32'h8765_4321, 5'd0,  3'b010, 32'h8765_4321, 1'b0);
        single("rol31", 32'h0000_0003, 5'd31, 3'b011, 32'h8000_0001, 1'b0);

        // Backpressure: 8 back-to-back, out_ready low for 7 cycles from first result
        first_stall = -1;
        out_before  = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(32'($urandom), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)),
                         5'(i), st);
                    if (st > 0 && first_stall < 0) first_stall = i;
                end
            end
            begin
                int w;
                w = 0;
                while (!out_valid && w < 100) begin
                    @(posedge clock);
                    #1;
                    w++;
                end
                out_ready = 1'b0;
                @(negedge clock);
                check("bp_full_in_ready", 64'(in_ready), 64'd0);
                check("bp_full_busy", 64'(busy), 64'd1);
                @(posedge clock);
                #1;
                repeat (6) begin
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        check("bp_first_stall_index", 64'(first_stall), 64'd5);
        drain("bp_drain");
        check("bp_result_count", 64'(n_out - out_before), 64'd8);

        // Random traffic with random backpressure
        rand_done  = 1'b0;
        out_before = n_out;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [2:0] m;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clock);
                        #1;
                    end
                    m = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4))
                                                   : 3'($urandom_range(5, 7));
                    send(32'($urandom), 5'($urandom_range(0, 31)), m, 5'(i), st);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("rand_drain");
        check("rand_result_count", 64'(n_out - out_before), 64'd1000);

        // Reset with 3 in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(32'($urandom), 5'd3, 3'b000, 5'(20 + i), st);
        reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        count_outputs(10, n);
        check("rst_no_stale", 64'(n), 64'd0);
        single("post_rst", 32'h0000_00F0, 5'd4, 3'b001, 32'h0000_000F, 1'b0);

        // Flush with 4 in flight and a same-cycle request
        for (int i = 0; i < 4; i++) send(32'($urandom), 5'd1, 3'b011, 5'(24 + i), st);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_tag   = 5'd31;
        @(negedge clock);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        count_outputs(10, n);
        check("flush_no_output", 64'(n), 64'd0);
        single("post_flush", 32'h0000_0001, 5'd7, 3'b000, 32'h0000_0080, 1'b0);

        // WIDTH=8 instance: ROL 0x81 by 1 with 3-stage latency
        in8_valid = 1'b1;
        in8_data  = 8'h81;
        in8_shamt = 3'd1;
        in8_mode  = 3'b011;
        in8_tag   = 5'd17;
        @(negedge clock);
        check("w8_in_ready", 64'(in8_ready), 64'd1);
        @(posedge clock);
        #1;
        in8_valid = 1'b0;
        lat = 1;
        while (!out8_valid && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("w8_latency", 64'(lat), 64'd3);
        check("w8_data", 64'(out8_data), 64'h03);
        check("w8_tag", 64'(out8_tag), 64'd17);
        check("w8_illegal", 64'(out8_illegal), 64'd0);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the ALU datapath; next generation of the combinational 32-bit logical-left shifter. Supports logical left/right, arithmetic right and both rotates at any power-of-two width, one shift level per register stage, with valid/ready flow control so the execute stage can stall it. It also carries a sideband tag so the issuing logic can match results to destination registers.

## Interface
- WIDTH, 32, data width; power of two, 8..64
- TAG_W, 5, sideband tag width; at least 1
- L (localparam), log2(WIDTH), shamt width and pipeline depth
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  request valid
- in_ready  out  1  request accepted this cycle when in_valid && in_ready
- in_data  in  WIDTH  operand
- in_shamt  in  L  shift amount, 0..WIDTH-1
- in_mode  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
- in_tag  in  TAG_W  opaque sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of this result
- out_illegal  out  1  request used a reserved mode
- busy  out  1  OR of all stage valid bits

## Operation
- L register stages S0..S(L-1). Each stage holds valid, data, remaining shamt, mode, tag and illegal.
- Stage Sk applies a shift of 2^(L-1-k) when shamt bit (L-1-k) is set. S0 applies the MSB weight and S(L-1) applies weight 1. Output ports are driven directly from S(L-1).
- SLL and SRL zero-fill. SRA fills with the current MSB, which equals the operand sign. ROL and ROR rotate modulo WIDTH.
- Reserved mode: data passes through unshifted and out_illegal=1 on that result.
- Advance rule (collapsible pipeline):
  - adv(L-1) = out_ready.
  - Sk advances into S(k+1) when Sk is valid and (S(k+1) is empty or adv(k+1)).
  - A stage that is not written keeps its contents.
- in_ready = !flush && (S0 empty || S0 advances). It is combinational from out_ready through the chain.
- Results leave in acceptance order. Bubbles collapse under backpressure. No transaction is dropped or duplicated.
- flush clears every stage valid bit on the next edge and discards any same-cycle input. Data registers are don't-care.
- reset_n low asynchronously clears all valid bits, data, tag and illegal. This applies mid-operation as well: in-flight work is lost and nothing emerges after release.

## Timing
- Reset values: out_valid=0, out_data=0, out_tag=0, out_illegal=0, busy=0. in_ready=1 whenever flush=0.
- Latency: request accepted in cycle c gives out_valid in cycle c+L when no backpressure occurs (5 cycles at WIDTH=32).
- Throughput: one result per cycle in steady state.
- Capacity: L transactions. When all stages are full and out_ready=0, in_ready=0.
- Full pipeline with out_ready=1: accept and emit occur in the same cycle, and in_ready stays 1.
- out_data, out_tag and out_illegal are stable while out_valid=1 and out_ready=0.
- shamt=0 in any mode returns in_data unchanged.

## Test plan
- WIDTH=32: SLL 0x0000_0001 by 31 -> 0x8000_0000. SRL 0x8000_0000 by 31 -> 0x0000_0001. Each with out_valid exactly 5 cycles after acceptance.
- SRA 0x8000_0010 by 4 -> 0xF800_0001. ROR 0x0000_00F1 by 4 -> 0x1000_000F. ROL 0x8000_0001 by 1 -> 0x0000_0003. Mode 111 on 0x1234_5678 -> 0x1234_5678 with out_illegal=1.
- Back-to-back stream of 8 requests, tags 0..7, out_ready held low for 7 cycles starting at the first out_valid. Required: in_ready drops after 5 requests are held, all 8 tags emerge in order, and no result is lost or repeated.
- Random out_ready (50%) with 1000 random requests against a reference model. Required: data, tag and order all match.
- Assert reset_n low for one cycle with 3 requests in flight, then release. Required: out_valid=0 immediately on assertion, busy=0, no stale results afterwards, and the next request emerges 5 cycles after acceptance.
- flush with 4 requests in flight and in_valid=1 in the same cycle. Required: nothing emerges from that cycle or before it. WIDTH=8 instance: ROL 0x81 by 1 -> 0x03 with latency 3.
